// File: rtl/lsu_wb_stage.sv
// lsu_wb_stage: memory-access and writeback stage.
//
// This stage takes results from EX and does one of two things with each one:
//   - For a non-memory op, it writes the ALU result back to the register bank.
//   - For a load or store, it runs an access on the data-memory bus. Load data
//     is lane-aligned and extended before it is written back.
// While a memory access is open, the stage holds EX off with stall_o.
//
// Ports
//   clk, rst_n              clock; synchronous active-low reset
//   valid_i .. write_en_i   instruction presented by EX
//   stall_o                 stage busy; EX must hold its instruction
//   misaligned_o            one-cycle pulse when a misaligned access is dropped
//   data_req_o .. data_wdata_o  data-memory request (word address, byte enables)
//   data_gnt_i, data_rvalid_i, data_rdata_i  data-memory grant / response
//   waddr_wb_o, wdata_wb_o, write_en_o       register-bank write port
//   state_dbg               current FSM state (0 idle, 1 req, 2 resp)
//
// Handshakes
//   EX -> stage:  an instruction transfers on a rising edge where valid_i is
//                 high and stall_o is low. EX holds its data while stall_o is high.
//   stage -> mem: a request transfers on a rising edge where data_req_o and
//                 data_gnt_i are both high. Until then, all request fields stay
//                 stable. Load data is taken on the first edge with
//                 data_rvalid_i high after the grant. An rvalid at any other
//                 time is ignored.
module lsu_wb_stage #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [WORD_WIDTH-1:0] alu_result_i,
  input  logic [WORD_WIDTH-1:0] store_data_i,
  input  logic                  load_i,
  input  logic                  store_i,
  input  logic [2:0]            load_type_i,
  input  logic [1:0]            store_type_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  write_en_i,
  output logic                  stall_o,
  output logic                  misaligned_o,
  output logic                  data_req_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [WORD_WIDTH-1:0] data_addr_o,
  output logic [WORD_WIDTH-1:0] data_wdata_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [WORD_WIDTH-1:0] data_rdata_i,
  output logic [ADDR_WIDTH-1:0] waddr_wb_o,
  output logic [WORD_WIDTH-1:0] wdata_wb_o,
  output logic                  write_en_o,
  output logic [1:0]            state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state;
  logic                  lat_load;
  logic [2:0]            lat_type;
  logic [1:0]            lat_off;
  logic [ADDR_WIDTH-1:0] lat_rd;
  logic                  lat_wen;

  logic                  accept;
  logic                  is_load;
  logic                  is_store;
  logic                  misaligned;
  logic [3:0]            store_be;
  logic [WORD_WIDTH-1:0] store_wdata;
  logic [WORD_WIDTH-1:0] lane;
  logic [WORD_WIDTH-1:0] load_ext;

  assign stall_o    = (state != S_IDLE);
  assign data_req_o = (state == S_REQ);
  assign state_dbg  = state;
  assign accept     = valid_i && (state == S_IDLE);

  // When load and store are both asserted, the instruction is treated as a load.
  assign is_load  = load_i;
  assign is_store = store_i && !load_i;

  // Alignment check. Any load type that is not byte or halfword is treated
  // as LW, so it also needs a word-aligned address.
  always_comb begin
    misaligned = 1'b0;
    if (is_load) begin
      case (load_type_i)
        3'b000, 3'b100: misaligned = 1'b0;
        3'b001, 3'b101: misaligned = alu_result_i[0];
        default:        misaligned = |alu_result_i[1:0];
      endcase
    end else if (is_store) begin
      case (store_type_i)
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = alu_result_i[0];
        default: misaligned = |alu_result_i[1:0];
      endcase
    end
  end

  // Store data is copied across all lanes, so memory can pick the right lane
  // using only the byte enables.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = store_data_i;
    case (store_type_i)
      2'b00: begin
        store_be    = 4'b0001 << alu_result_i[1:0];
        store_wdata = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        store_be    = 4'b0011 << {alu_result_i[1], 1'b0};
        store_wdata = {2{store_data_i[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = store_data_i;
      end
    endcase
  end

  // Shift the addressed byte or halfword down to bit 0, then extend it.
  assign lane = data_rdata_i >> {lat_off, 3'b000};

  always_comb begin
    load_ext = lane;
    case (lat_type)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_ext = {24'd0, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      lat_load     <= 1'b0;
      lat_type     <= 3'd0;
      lat_off      <= 2'd0;
      lat_rd       <= '0;
      lat_wen      <= 1'b0;
      misaligned_o <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'd0;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
      waddr_wb_o   <= '0;
      wdata_wb_o   <= '0;
      write_en_o   <= 1'b0;
    end else begin
      write_en_o   <= 1'b0;
      misaligned_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!is_load && !is_store) begin
              waddr_wb_o <= rd_addr_i;
              wdata_wb_o <= alu_result_i;
              write_en_o <= write_en_i && (rd_addr_i != '0);
            end else if (misaligned) begin
              misaligned_o <= 1'b1;
            end else begin
              lat_load     <= is_load;
              lat_type     <= load_type_i;
              lat_off      <= alu_result_i[1:0];
              lat_rd       <= rd_addr_i;
              lat_wen      <= write_en_i;
              data_we_o    <= is_store;
              data_be_o    <= is_store ? store_be : 4'b1111;
              data_addr_o  <= {alu_result_i[WORD_WIDTH-1:2], 2'b00};
              data_wdata_o <= is_store ? store_wdata : '0;
              state        <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (data_gnt_i) begin
            state <= lat_load ? S_RESP : S_IDLE;
          end
        end
        S_RESP: begin
          if (data_rvalid_i) begin
            waddr_wb_o <= lat_rd;
            wdata_wb_o <= load_ext;
            write_en_o <= lat_wen && (lat_rd != '0);
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Directed testbench for lsu_wb_stage.
//
// Driver tasks apply one instruction each and play the memory side.
// A reference model works out the expected writebacks and bus requests.
// One compare process checks the DUT against the model on every falling edge.
module tb_lsu_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] alu_result_i;
  logic [31:0] store_data_i;
  logic        load_i;
  logic        store_i;
  logic [2:0]  load_type_i;
  logic [1:0]  store_type_i;
  logic [4:0]  rd_addr_i;
  logic        write_en_i;
  logic        stall_o;
  logic        misaligned_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic [4:0]  waddr_wb_o;
  logic [31:0] wdata_wb_o;
  logic        write_en_o;
  logic [1:0]  state_dbg;

  lsu_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .alu_result_i(alu_result_i),
    .store_data_i(store_data_i), .load_i(load_i), .store_i(store_i),
    .load_type_i(load_type_i), .store_type_i(store_type_i), .rd_addr_i(rd_addr_i),
    .write_en_i(write_en_i), .stall_o(stall_o), .misaligned_o(misaligned_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .waddr_wb_o(waddr_wb_o), .wdata_wb_o(wdata_wb_o), .write_en_o(write_en_o),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic [36:0] exp_q[$];      // expected writebacks: {rd, data}
  req_t        exp_req_q[$];  // expected bus requests
  int vectors     = 0;
  int miscompares = 0;
  int mis_exp     = 0;
  int mis_seen    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int access_size(input logic is_load, input logic [2:0] lt,
                                     input logic [1:0] st);
    if (is_load) return (lt == 3'b000 || lt == 3'b100) ? 1 :
                        (lt == 3'b001 || lt == 3'b101) ? 2 : 4;
    return (st == 2'b00) ? 1 : (st == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_misaligned(input logic is_load, input logic [2:0] lt,
                                            input logic [1:0] st, input logic [31:0] a);
    return (a % access_size(is_load, lt, st)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [31:0] a,
                                             input logic [31:0] rdata);
    logic [31:0] s;
    int off;
    off = a % 4;
    s = rdata >> (8 * off);
    case (lt)
      3'b000:  return 32'($signed(s[7:0]));
      3'b100:  return 32'(s[7:0]);
      3'b001:  return 32'($signed(s[15:0]));
      3'b101:  return 32'(s[15:0]);
      default: return rdata;
    endcase
  endfunction

  function automatic req_t model_store(input logic [1:0] st, input logic [31:0] a,
                                       input logic [31:0] d);
    req_t r;
    int sz;
    sz = access_size(1'b0, 3'b000, st);
    r.we    = 1'b1;
    r.addr  = a & 32'hFFFF_FFFC;
    r.be    = 4'(((1 << sz) - 1) << (a % 4));
    r.wdata = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
    return r;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (write_en_o) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL wb_unexpected: got rd=%0d data=%h expected no write", waddr_wb_o, wdata_wb_o);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          if ({waddr_wb_o, wdata_wb_o} !== e) begin
            miscompares++;
            $display("FAIL wb_data: got rd=%0d data=%h expected rd=%0d data=%h",
                     waddr_wb_o, wdata_wb_o, e[36:32], e[31:0]);
          end
        end
      end
      if (misaligned_o) mis_seen++;
      if (data_req_o) begin
        vectors++;
        if (exp_req_q.size() == 0) begin
          miscompares++;
          $display("FAIL req_unexpected: got addr=%h we=%b expected no request", data_addr_o, data_we_o);
        end else begin
          req_t e;
          e = exp_req_q[0];
          if (data_we_o !== e.we || data_addr_o !== e.addr ||
              (e.we && (data_be_o !== e.be || data_wdata_o !== e.wdata))) begin
            miscompares++;
            $display("FAIL req_fields: got we=%b addr=%h be=%b wdata=%h expected we=%b addr=%h be=%b wdata=%h",
                     data_we_o, data_addr_o, data_be_o, data_wdata_o, e.we, e.addr, e.be, e.wdata);
          end
          if (data_gnt_i) void'(exp_req_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0;
  endtask

  task automatic issue_alu(input logic [4:0] rd, input logic [31:0] res, input logic wen);
    logic exp_we;
    valid_i = 1'b1; load_i = 1'b0; store_i = 1'b0;
    alu_result_i = res; rd_addr_i = rd; write_en_i = wen;
    exp_we = wen && (rd != 5'd0);
    if (exp_we) exp_q.push_back({rd, res});
    tick();
    idle_inputs();
    @(negedge clk);
    check("alu_we", 32'(write_en_o), 32'(exp_we));
    check("alu_waddr", 32'(waddr_wb_o), 32'(rd));
    check("alu_wdata", wdata_wb_o, res);
    tick();
    @(negedge clk);
    check("alu_we_one_cycle", 32'(write_en_o), 32'd0);
  endtask

  task automatic mem_load(input logic [31:0] addr, input logic [2:0] lt, input logic [4:0] rd,
                          input logic also_store, input logic [31:0] rdata,
                          input int gnt_lat, input int rv_lat, input logic [31:0] exp_wd);
    req_t r;
    valid_i = 1'b1; load_i = 1'b1; store_i = also_store;
    load_type_i = lt; store_type_i = 2'b10; alu_result_i = addr;
    store_data_i = 32'hFFFF_FFFF; rd_addr_i = rd; write_en_i = 1'b1;
    r.we = 1'b0; r.be = 4'hF; r.addr = addr & 32'hFFFF_FFFC; r.wdata = '0;
    exp_req_q.push_back(r);
    if (rd != 5'd0) exp_q.push_back({rd, model_load(lt, addr, rdata)});
    tick();
    idle_inputs();
    for (int i = 0; i < gnt_lat; i++) begin
      // A stray rvalid before the grant must be ignored.
      data_rvalid_i = 1'b1; data_rdata_i = $urandom;
      @(negedge clk);
      check("ld_stall_req", 32'(stall_o), 32'd1);
      check("ld_req_held", 32'(data_req_o), 32'd1);
      tick();
    end
    data_rvalid_i = 1'b0;
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    for (int i = 0; i < rv_lat; i++) begin
      @(negedge clk);
      check("ld_stall_resp", 32'(stall_o), 32'd1);
      check("ld_no_req_resp", 32'(data_req_o), 32'd0);
      tick();
    end
    data_rvalid_i = 1'b1; data_rdata_i = rdata;
    tick();
    data_rvalid_i = 1'b0; data_rdata_i = $urandom;
    @(negedge clk);
    check("ld_we", 32'(write_en_o), 32'(rd != 5'd0));
    check("ld_waddr", 32'(waddr_wb_o), 32'(rd));
    check("ld_wdata", wdata_wb_o, exp_wd);
    check("ld_stall_done", 32'(stall_o), 32'd0);
  endtask

  task automatic mem_store(input logic [31:0] addr, input logic [1:0] st, input logic [31:0] d,
                           input int gnt_lat, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    valid_i = 1'b1; load_i = 1'b0; store_i = 1'b1;
    store_type_i = st; alu_result_i = addr; store_data_i = d;
    rd_addr_i = 5'd9; write_en_i = 1'b1;
    exp_req_q.push_back(model_store(st, addr, d));
    tick();
    idle_inputs();
    repeat (gnt_lat) tick();
    data_gnt_i = 1'b1;
    @(negedge clk);
    check("st_be", 32'(data_be_o), 32'(exp_be));
    check("st_wdata", data_wdata_o, exp_wd);
    check("st_we", 32'(data_we_o), 32'd1);
    check("st_addr", data_addr_o, addr & 32'hFFFF_FFFC);
    tick();
    data_gnt_i = 1'b0;
    @(negedge clk);
    check("st_no_wb", 32'(write_en_o), 32'd0);
    check("st_stall_done", 32'(stall_o), 32'd0);
    check("st_req_done", 32'(data_req_o), 32'd0);
  endtask

  task automatic mem_misaligned(input logic is_load, input logic [2:0] lt, input logic [1:0] st,
                                input logic [31:0] addr);
    check("mis_model", 32'(model_misaligned(is_load, lt, st, addr)), 32'd1);
    valid_i = 1'b1; load_i = is_load; store_i = !is_load;
    load_type_i = lt; store_type_i = st; alu_result_i = addr;
    store_data_i = 32'h5555_AAAA; rd_addr_i = 5'd4; write_en_i = 1'b1;
    mis_exp++;
    tick();
    idle_inputs();
    @(negedge clk);
    check("mis_pulse", 32'(misaligned_o), 32'd1);
    check("mis_no_stall", 32'(stall_o), 32'd0);
    check("mis_no_req", 32'(data_req_o), 32'd0);
    check("mis_no_wb", 32'(write_en_o), 32'd0);
    tick();
    @(negedge clk);
    check("mis_pulse_end", 32'(misaligned_o), 32'd0);
    check("mis_no_req2", 32'(data_req_o), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 32'(write_en_o), 32'd0);
    check({tag, "_req"}, 32'(data_req_o), 32'd0);
    check({tag, "_stall"}, 32'(stall_o), 32'd0);
    check({tag, "_mis"}, 32'(misaligned_o), 32'd0);
    check({tag, "_waddr"}, 32'(waddr_wb_o), 32'd0);
    check({tag, "_wdata"}, wdata_wb_o, 32'd0);
    check({tag, "_be"}, 32'(data_be_o), 32'd0);
    check({tag, "_addr"}, data_addr_o, 32'd0);
    check({tag, "_dwe"}, 32'(data_we_o), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; idle_inputs();
    alu_result_i = '0; store_data_i = '0; load_type_i = '0; store_type_i = '0;
    rd_addr_i = '0; write_en_i = 1'b0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;

    // ALU writeback, including the rd=0 and write_en_i=0 suppressions
    issue_alu(5'd5, 32'h0000_1234, 1'b1);
    issue_alu(5'd0, 32'h0000_DEAD, 1'b1);
    issue_alu(5'd7, 32'hABCD_0001, 1'b0);

    // Loads: lane extraction, sign/zero extension, grant/response latency
    mem_load(32'h103, 3'b000, 5'd1, 1'b0, 32'h80FF_FF00, 2, 0, 32'hFFFF_FF80);
    mem_load(32'h102, 3'b101, 5'd2, 1'b0, 32'hBEEF_0000, 0, 1, 32'h0000_BEEF);
    mem_load(32'h102, 3'b001, 5'd3, 1'b0, 32'hBEEF_0000, 1, 0, 32'hFFFF_BEEF);
    mem_load(32'h101, 3'b100, 5'd6, 1'b0, 32'h1234_8000, 0, 0, 32'h0000_0080);
    mem_load(32'h100, 3'b010, 5'd8, 1'b0, 32'hCAFE_F00D, 1, 2, 32'hCAFE_F00D);
    mem_load(32'h104, 3'b011, 5'd10, 1'b0, 32'h1122_3344, 0, 0, 32'h1122_3344);
    mem_load(32'h108, 3'b010, 5'd11, 1'b1, 32'h0BAD_F00D, 0, 0, 32'h0BAD_F00D);

    // Stores: byte enables and lane replication, no writeback
    mem_store(32'h202, 2'b01, 32'h1234_5678, 1, 4'b1100, 32'h5678_5678);
    mem_store(32'h301, 2'b00, 32'h0000_00AB, 0, 4'b0010, 32'hABAB_ABAB);
    mem_store(32'h400, 2'b10, 32'hDEAD_BEEF, 2, 4'b1111, 32'hDEAD_BEEF);

    // Misaligned accesses are dropped
    mem_misaligned(1'b1, 3'b010, 2'b00, 32'h101);
    mem_misaligned(1'b1, 3'b001, 2'b00, 32'h103);
    mem_misaligned(1'b0, 3'b000, 2'b01, 32'h201);
    mem_misaligned(1'b0, 3'b000, 2'b10, 32'h402);

    // Back-to-back: ALU op accepted right after the load's response cycle
    mem_load(32'h500, 3'b010, 5'd12, 1'b0, 32'h7777_0000, 0, 0, 32'h7777_0000);
    issue_alu(5'd13, 32'h0000_0042, 1'b1);

    // Reset while waiting for load data abandons the access
    begin
      req_t r;
      valid_i = 1'b1; load_i = 1'b1; store_i = 1'b0; load_type_i = 3'b010;
      alu_result_i = 32'h600; rd_addr_i = 5'd14; write_en_i = 1'b1;
      r.we = 1'b0; r.be = 4'hF; r.addr = 32'h600; r.wdata = '0;
      exp_req_q.push_back(r);
      tick();
      idle_inputs();
      data_gnt_i = 1'b1;
      tick();
      data_gnt_i = 1'b0;
      @(negedge clk);
      check("rst_in_resp_stall", 32'(stall_o), 32'd1);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("mid_reset");
      tick();
      data_rvalid_i = 1'b1; data_rdata_i = 32'h9999_9999;
      tick();
      data_rvalid_i = 1'b0;
      @(negedge clk);
      check("rst_late_rvalid_we", 32'(write_en_o), 32'd0);
      check("rst_late_rvalid_stall", 32'(stall_o), 32'd0);
    end

    // Stage still works after the abandoned access
    issue_alu(5'd15, 32'h0F0F_0F0F, 1'b1);

    repeat (2) tick();
    check("wb_queue_drained", 32'(exp_q.size()), 32'd0);
    check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    check("misaligned_pulses", 32'(mis_seen), 32'(mis_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
